// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA raster generator.
package vga_pkg;

   typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} axis_state_e;

   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CW       = 12;

   localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: ACTIVE -> FP -> SYNC -> BP segment FSM with position counter,
// registered sync level and an end-of-axis wrap pulse.
module vga_axis_fsm
   import vga_pkg::*;
#(
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP,
   parameter bit POL    = 1'b0,
   parameter int CW     = VGA_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step_i,
   output axis_state_e   state_nxt_o,
   output logic [CW-1:0] pos_o,
   output logic          sync_o,
   output logic          wrap_o
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
      $error("vga_axis_fsm: every segment length must be at least 1");
   end
   if (TOTAL - 1 >= (2 ** CW)) begin : g_bad_cw
      $error("vga_axis_fsm: CW too narrow for TOTAL-1");
   end

   axis_state_e   state_q, state_d;
   logic [CW-1:0] seg_q, seg_d;
   logic [CW-1:0] pos_q, pos_d;
   logic          sync_q, sync_d;
   logic [CW-1:0] seg_last;
   logic          wrap;

   always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      pos_d    = pos_q;
      wrap     = 1'b0;
      seg_last = '0;
      case (state_q)
         ST_ACTIVE: seg_last = CW'(ACTIVE - 1);
         ST_FP:     seg_last = CW'(FP - 1);
         ST_SYNC:   seg_last = CW'(SYNC - 1);
         ST_BP:     seg_last = CW'(BP - 1);
         default:   seg_last = '0;
      endcase
      if (step_i) begin
         if (seg_q == seg_last) begin
            seg_d = '0;
            case (state_q)
               ST_ACTIVE: state_d = ST_FP;
               ST_FP:     state_d = ST_SYNC;
               ST_SYNC:   state_d = ST_BP;
               default:   state_d = ST_ACTIVE;
            endcase
         end else begin
            seg_d = seg_q + 1'b1;
         end
         // Leaving BP is the last position of the axis.
         if (state_q == ST_BP && seg_q == seg_last) begin
            wrap  = 1'b1;
            pos_d = '0;
         end else begin
            pos_d = pos_q + 1'b1;
         end
      end
      sync_d = (state_d == ST_SYNC) ? POL : ~POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACTIVE;
         seg_q   <= '0;
         pos_q   <= '0;
         sync_q  <= ~POL;
      end else begin
         state_q <= state_d;
         seg_q   <= seg_d;
         pos_q   <= pos_d;
         sync_q  <= sync_d;
      end
   end

   assign state_nxt_o = state_d;
   assign pos_o       = pos_q;
   assign sync_o      = sync_q;
   assign wrap_o      = wrap;

endmodule

// File: rtl/vga_timing_fsm.sv
// VGA raster timing generator driven by a one-clk pixel-enable tick.
// Define VGA_TIMING_SYNC_ALIGN_EN to delay hsync/vsync/video_on by two pixel ticks.
module vga_timing_fsm
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = VGA_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          line_start,
   output logic          frame_start
);

   axis_state_e h_nxt, v_nxt;
   logic        h_sync, v_sync;
   logic        h_wrap, v_wrap;
   logic        v_step;

   assign v_step = h_wrap & pix_en;

   vga_axis_fsm #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
   ) u_h_axis (
      .clk         (clk),
      .rst         (rst),
      .step_i      (pix_en),
      .state_nxt_o (h_nxt),
      .pos_o       (pix_x),
      .sync_o      (h_sync),
      .wrap_o      (h_wrap)
   );

   vga_axis_fsm #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
   ) u_v_axis (
      .clk         (clk),
      .rst         (rst),
      .step_i      (v_step),
      .state_nxt_o (v_nxt),
      .pos_o       (pix_y),
      .sync_o      (v_sync),
      .wrap_o      (v_wrap)
   );

   logic video_on_q, video_on_d;
   logic line_q, line_d;
   logic frame_q, frame_d;

   always_comb begin
      video_on_d = video_on_q;
      if (pix_en) begin
         video_on_d = (h_nxt == ST_ACTIVE) && (v_nxt == ST_ACTIVE);
      end
      // Strobes are single-clk pulses; wraps only fire on pix_en cycles.
      line_d  = h_wrap;
      frame_d = h_wrap & v_wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         video_on_q <= 1'b1;
         line_q     <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         video_on_q <= video_on_d;
         line_q     <= line_d;
         frame_q    <= frame_d;
      end
   end

   assign line_start  = line_q;
   assign frame_start = frame_q;

`ifdef VGA_TIMING_SYNC_ALIGN_EN
   logic [1:0] hs_dly_q, vs_dly_q, vid_dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_dly_q  <= {2{~HS_POL}};
         vs_dly_q  <= {2{~VS_POL}};
         vid_dly_q <= 2'b00;
      end else if (pix_en) begin
         hs_dly_q  <= {hs_dly_q[0], h_sync};
         vs_dly_q  <= {vs_dly_q[0], v_sync};
         vid_dly_q <= {vid_dly_q[0], video_on_q};
      end
   end

   assign hsync    = hs_dly_q[1];
   assign vsync    = vs_dly_q[1];
   assign video_on = vid_dly_q[1];
`else
   assign hsync    = h_sync;
   assign vsync    = v_sync;
   assign video_on = video_on_q;
`endif

endmodule

// File: tb/tb_vga_timing_fsm.sv
// Directed bench: full-size 640x480 instance for line timing, small instance
// with inverted polarities for whole-frame timing.
module tb_vga_timing_fsm;

`ifdef VGA_TIMING_SYNC_ALIGN_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pe_a = 1'b0;
   logic        pe_b = 1'b0;

   logic        hs_a, vs_a, vid_a, ls_a, fs_a;
   logic [11:0] x_a, y_a;
   logic        hs_b, vs_b, vid_b, ls_b, fs_b;
   logic [11:0] x_b, y_b;

   int n_tests = 0;
   int n_fail  = 0;
   int n_a = 0;
   int n_b = 0;

   always #5 clk = ~clk;

   vga_timing_fsm u_dut_a (
      .clk(clk), .rst(rst), .pix_en(pe_a),
      .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
      .pix_x(x_a), .pix_y(y_a), .line_start(ls_a), .frame_start(fs_a)
   );

   vga_timing_fsm #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
   ) u_dut_b (
      .clk(clk), .rst(rst), .pix_en(pe_b),
      .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
      .pix_x(x_b), .pix_y(y_b), .line_start(ls_b), .frame_start(fs_b)
   );

   // Expected {hsync,vsync,video_on,line_start,frame_start,pix_x,pix_y} after n pixel ticks.
   function automatic logic [28:0] model(input int n, input bit strb,
                                         input int ha, input int hf, input int hs, input int hb,
                                         input int va, input int vf, input int vs, input int vb,
                                         input bit hp, input bit vp);
      int ht, vt, x, y, m, mx, my;
      logic h, v, vid, ls, fs;
      logic [11:0] xs, ys;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      x  = n % ht;
      y  = (n / ht) % vt;
      ls = strb && (n > 0) && (x == 0);
      fs = ls && (y == 0);
      if (n < DLY) begin
         h = ~hp; v = ~vp; vid = 1'b0;
      end else begin
         m   = n - DLY;
         mx  = m % ht;
         my  = (m / ht) % vt;
         h   = (mx >= ha + hf && mx < ha + hf + hs) ? hp : ~hp;
         v   = (my >= va + vf && my < va + vf + vs) ? vp : ~vp;
         vid = (mx < ha) && (my < va);
      end
      xs = 12'(x);
      ys = 12'(y);
      return {h, v, vid, ls, fs, xs, ys};
   endfunction

   function automatic logic [28:0] exp_a(input int n, input bit strb);
      return model(n, strb, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction

   function automatic logic [28:0] exp_b(input int n, input bit strb);
      return model(n, strb, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pe_a = 1'b1; pe_b = 1'b1;
      tick(); tick();
      n_a = 0; n_b = 0;
      n_tests++;
      if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_a got=%h exp=%h", {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(0, 1'b1));
      end
      n_tests++;
      if ({hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b} !== exp_b(0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_b got=%h exp=%h", {hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b}, exp_b(0, 1'b1));
      end
      rst = 1'b0; pe_a = 1'b0; pe_b = 1'b0;
   endtask

   task automatic test_line();
      int ls_cnt = 0;
      int hs_low = 0;
      pe_a = 1'b1;
      for (int i = 0; i < 800; i++) begin
         tick();
         n_a++;
         n_tests++;
         if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(n_a, 1'b1)) begin
            n_fail++;
            $display("FAIL line n=%0d got=%h exp=%h", n_a, {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(n_a, 1'b1));
         end
         if (ls_a) ls_cnt++;
         if (!hs_a) hs_low++;
      end
      pe_a = 1'b0;
      n_tests++;
      if (ls_cnt !== 1) begin
         n_fail++;
         $display("FAIL line_start_count got=%0d exp=1", ls_cnt);
      end
      n_tests++;
      if (hs_low !== 96) begin
         n_fail++;
         $display("FAIL hsync_low_count got=%0d exp=96", hs_low);
      end
   endtask

   task automatic test_sparse_en();
      int ls_cnt = 0;
      for (int i = 0; i < 3200; i++) begin
         pe_a = (i % 4 == 0);
         tick();
         if (pe_a) n_a++;
         n_tests++;
         if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(n_a, pe_a)) begin
            n_fail++;
            $display("FAIL sparse i=%0d got=%h exp=%h", i, {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(n_a, pe_a));
         end
         if (ls_a) ls_cnt++;
      end
      pe_a = 1'b0;
      n_tests++;
      if (ls_cnt !== 1) begin
         n_fail++;
         $display("FAIL sparse_line_count got=%0d exp=1", ls_cnt);
      end
   endtask

   task automatic test_reset_midline();
      int guard = 0;
      pe_a = 1'b1;
      while (x_a !== 12'd700 && guard < 900) begin
         tick();
         n_a++;
         guard++;
      end
      n_tests++;
      if (x_a !== 12'd700) begin
         n_fail++;
         $display("FAIL reach_x700 got=%0d exp=700", x_a);
      end
      rst = 1'b1;
      tick();
      n_a = 0; n_b = 0;
      n_tests++;
      if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_midline got=%h exp=%h", {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(0, 1'b1));
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_a++;
         n_tests++;
         if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(n_a, 1'b1)) begin
            n_fail++;
            $display("FAIL after_reset n=%0d got=%h exp=%h", n_a, {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(n_a, 1'b1));
         end
      end
      pe_a = 1'b0;
   endtask

   task automatic test_frame();
      int fs_cnt = 0;
      int vs_cnt = 0;
      int vid_cnt = 0;
      pe_b = 1'b1;
      for (int i = 0; i < 240; i++) begin
         tick();
         n_b++;
         n_tests++;
         if ({hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b} !== exp_b(n_b, 1'b1)) begin
            n_fail++;
            $display("FAIL frame n=%0d got=%h exp=%h", n_b, {hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b}, exp_b(n_b, 1'b1));
         end
         if (fs_b) fs_cnt++;
         if (vs_b) vs_cnt++;
         if (vid_b) vid_cnt++;
      end
      pe_b = 1'b0;
      n_tests++;
      if (fs_cnt !== 2) begin
         n_fail++;
         $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
      end
      n_tests++;
      if (vs_cnt !== 60) begin
         n_fail++;
         $display("FAIL vsync_active_count got=%0d exp=60", vs_cnt);
      end
      n_tests++;
      if (vid_cnt !== 64) begin
         n_fail++;
         $display("FAIL video_on_count got=%0d exp=64", vid_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      int guard = 0;
      pe_b = 1'b1;
      while (!(y_b === 12'd3 && x_b === 12'd5) && guard < 200) begin
         tick();
         n_b++;
         guard++;
      end
      n_tests++;
      if (!(y_b === 12'd3 && x_b === 12'd5)) begin
         n_fail++;
         $display("FAIL reach_3_5 got=(%0d,%0d) exp=(5,3)", x_b, y_b);
      end
      rst = 1'b1;
      tick();
      n_b = 0; n_a = 0;
      rst = 1'b0;
      pe_b = 1'b0;
      n_tests++;
      if ({hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b} !== exp_b(0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_midframe got=%h exp=%h", {hs_b, vs_b, vid_b, ls_b, fs_b, x_b, y_b}, exp_b(0, 1'b1));
      end
      n_tests++;
      if ({hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a} !== exp_a(0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_idle_a got=%h exp=%h", {hs_a, vs_a, vid_a, ls_a, fs_a, x_a, y_a}, exp_a(0, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_sparse_en();
      test_reset_midline();
      test_frame();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_fsm.md
Name: vga_timing_fsm

Overview:
Raster timing generator that sits directly downstream of the pixel-rate divider counter. It consumes that counter's one-cycle terminal-count pulse as a pixel-enable. Two chained per-axis state machines (horizontal, vertical) produce hsync, vsync, the active-video flag, raster coordinates and line/frame strobes for the pixel pipeline and the VGA output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch length in pixels
H_SYNC, 96, hsync pulse length in pixels
H_BP, 48, horizontal back porch length in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch length in lines
V_SYNC, 2, vsync pulse length in lines
V_BP, 33, vertical back porch length in lines
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CW, 12, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel tick, one clk wide, from the divider terminal count
hsync  out  1  horizontal sync at HS_POL when asserted
vsync  out  1  vertical sync at VS_POL when asserted
video_on  out  1  high when both axes are in ACTIVE
pix_x  out  CW  horizontal position, 0..H_TOTAL-1
pix_y  out  CW  vertical position, 0..V_TOTAL-1
line_start  out  1  one-clk pulse when pix_x wraps to 0
frame_start  out  1  one-clk pulse when pix_x and pix_y both wrap to 0

Behaviour:
- Reset is synchronous, active-high, on reset rst and clock clk, and overrides pix_en. Reset values:
  - both FSMs in ACTIVE; segment counters, pix_x and pix_y = 0
  - hsync = ~HS_POL, vsync = ~VS_POL, video_on = 1
  - line_start = frame_start = 0
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the same sum over the V_ parameters.
- All outputs are registered. They change only on the clk edge where pix_en = 1, so latency is 1 clk from the pix_en sample. With pix_en = 0, every register holds.
- Per-axis FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - Each state has a segment counter that runs 0..LEN-1. The transition happens on the advance where the counter equals LEN-1; the counter then clears to 0.
- Horizontal FSM advances on every pix_en. pix_x increments by 1 and wraps H_TOTAL-1 -> 0.
- Vertical FSM advances only on a pix_en where the horizontal FSM leaves BP (end of line). pix_y wraps V_TOTAL-1 -> 0 on that same edge.
- hsync = HS_POL exactly while the H FSM is in SYNC (H_SYNC pixels). vsync = VS_POL exactly while the V FSM is in SYNC (V_SYNC full lines, aligned to line start).
- video_on = (H state == ACTIVE) && (V state == ACTIVE), registered together with the coordinates.
- line_start is high for one clk on the edge where pix_x becomes 0. It is not raised by reset.
- frame_start is high for one clk on the edge where pix_x and pix_y both become 0. It always coincides with line_start.
- Reset mid-line: the next clk returns to the reset values. The first frame after reset is complete and starts at (0,0).
- Any parameter LEN = 0 is illegal. An elaboration-time check must flag it.

Optional Feature:
Macro VGA_TIMING_SYNC_ALIGN_EN.
- Defined: hsync, vsync and video_on pass through a 2-deep shift register advanced on pix_en. This aligns them with a 2-stage framebuffer read pipeline. pix_x, pix_y, line_start and frame_start are not delayed. The delay stages reset to the inactive levels, with video_on = 0.
- Undefined: no delay; timing is exactly as in Behaviour.

Decomposition:
- Shared package vga_pkg holds:
  - axis state typedef {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP}
  - 640x480@60 timing constants
  - H_TOTAL/V_TOTAL derivation
- Natural sub-module: vga_axis_fsm.
  - Parameters: ACTIVE/FP/SYNC/BP/POL/CW.
  - Inputs: step.
  - Outputs: state, position, sync, wrap.
  - Instantiated twice: H stepped by pix_en; V stepped by the H wrap AND pix_en.

Test Plan:
- Reset then pix_en held high for 800 clks -> pix_x runs 0..799 then 0; hsync low exactly while pix_x = 656..751; line_start pulses once, on the edge where pix_x becomes 0.
- pix_en pulsed once every 4 clks -> outputs change only on pix_en edges; 3200 clks give exactly one line.
- Full frame of 420000 pix_en -> vsync low for pix_y = 490..491 across all pixels of those lines; video_on count = 307200; frame_start exactly once, at (0,0).
- rst asserted at pix_x=700, pix_y=300 with pix_en = 1 -> next clk: pix_x = pix_y = 0, hsync = vsync = 1, video_on = 1, no strobe.
- Elaborate with HS_POL = 1, VS_POL = 1 -> sync pulses invert; pulse positions are unchanged.
- With VGA_TIMING_SYNC_ALIGN_EN: hsync falls 2 pix_en after pix_x reaches 656, video_on drops 2 pix_en after pix_x reaches 640, and the coordinates are unchanged.
